// File: rtl/alarm_pkg.sv
// Shared definitions for the multi-zone alarm controller: state codes and
// the width of the per-zone retrigger counters.
package alarm_pkg;

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_ARMING   = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4,
    S_SILENCE  = 3'd5
  } state_t;

  localparam int RC_W = 3;

endpackage

// File: rtl/second_timer.sv
// Seconds prescaler plus a loadable down-counter; expired pulses on the tick
// that takes the count from 1 to 0, or one cycle after a load of zero.
module second_timer #(
  parameter int CLK_HZ = 100000000,
  parameter int TW     = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          tick,
  output logic [TW-1:0] time_left,
  output logic          expired
);

  localparam int            PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc;
  logic          zero_pend;

  assign tick    = (presc == LAST);
  assign expired = zero_pend | (tick & (time_left == TW'(1)));

  // A load restarts the second so the timeout is exactly V whole seconds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc     <= '0;
      time_left <= '0;
      zero_pend <= 1'b0;
    end else if (load) begin
      presc     <= '0;
      time_left <= load_val;
      zero_pend <= (load_val == '0);
    end else begin
      presc     <= tick ? '0 : presc + PW'(1);
      zero_pend <= 1'b0;
      if (tick && (time_left != '0))
        time_left <= time_left - TW'(1);
    end
  end

endmodule

// File: rtl/multi_zone_alarm_fsm.sv
// Multi-zone intrusion alarm controller: arm / exit delay / entry delay /
// alarm / silence sequencing with per-zone trip history and auto-bypass.
module multi_zone_alarm_fsm
  import alarm_pkg::*;
#(
  parameter int N_ZONES    = 4,
  parameter int CLK_HZ     = 100000000,
  parameter int TW         = 4,
  parameter int MAX_RETRIG = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ignition,
  input  logic [N_ZONES-1:0] zone,
  input  logic [N_ZONES-1:0] entry_mask,
  input  logic [TW-1:0]      arm_delay,
  input  logic [TW-1:0]      entry_delay,
  input  logic [TW-1:0]      alarm_time,
  output logic [2:0]         state,
  output logic               status,
  output logic               enable_siren,
  output logic [N_ZONES-1:0] tripped,
  output logic [N_ZONES-1:0] bypassed,
  output logic [TW-1:0]      time_left,
  output logic               tick
);

  localparam logic [RC_W-1:0] RETRIG_LIM = RC_W'(MAX_RETRIG);

  state_t             cur_state, nxt_state;
  logic               door_seen, door_nxt;
  logic               blink;
  logic               load;
  logic [TW-1:0]      load_val;
  logic               expired;
  logic               trip_evt, stuck_evt, clear_all;
  logic [N_ZONES-1:0] act, inst_hit, ent_hit;

  assign act      = zone & ~bypassed;
  assign inst_hit = act & ~entry_mask;
  assign ent_hit  = act & entry_mask;
  assign state    = cur_state;

  second_timer #(
    .CLK_HZ (CLK_HZ),
    .TW     (TW)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .load_val  (load_val),
    .tick      (tick),
    .time_left (time_left),
    .expired   (expired)
  );

  always_comb begin
    nxt_state = cur_state;
    door_nxt  = door_seen;
    load      = 1'b0;
    load_val  = '0;
    trip_evt  = 1'b0;
    stuck_evt = 1'b0;
    clear_all = 1'b0;
    if (ignition) begin
      nxt_state = S_DISARMED;
      door_nxt  = 1'b0;
      clear_all = 1'b1;
    end else begin
      case (cur_state)
        S_DISARMED: begin
          if (door_seen && (zone == '0)) begin
            nxt_state = S_ARMING;
            load      = 1'b1;
            load_val  = arm_delay;
            door_nxt  = 1'b0;
          end else if (|(zone & entry_mask)) begin
            door_nxt = 1'b1;
          end
        end
        S_ARMING: begin
          if (|zone) begin
            nxt_state = S_DISARMED;
            door_nxt  = 1'b1;
          end else if (expired) begin
            nxt_state = S_ARMED;
          end
        end
        S_ARMED: begin
          if (|inst_hit) begin
            nxt_state = S_ALARM;
            load      = 1'b1;
            load_val  = alarm_time;
            trip_evt  = 1'b1;
          end else if (|ent_hit) begin
            nxt_state = S_ENTRY;
            load      = 1'b1;
            load_val  = entry_delay;
          end
        end
        S_ENTRY: begin
          if ((|inst_hit) || expired) begin
            nxt_state = S_ALARM;
            load      = 1'b1;
            load_val  = alarm_time;
            trip_evt  = 1'b1;
          end
        end
        S_ALARM: begin
          if (act == '0) begin
            nxt_state = S_SILENCE;
            load      = 1'b1;
            load_val  = alarm_time;
          end else if (expired) begin
            nxt_state = S_ARMED;
            stuck_evt = 1'b1;
          end
        end
        S_SILENCE: begin
          // Re-entry from silence is the same incident, so no trip event.
          if (|act) begin
            nxt_state = S_ALARM;
            load      = 1'b1;
            load_val  = alarm_time;
          end else if (expired) begin
            nxt_state = S_ARMED;
          end
        end
        default: nxt_state = S_DISARMED;
      endcase
    end
  end

  // Outputs decode the registered state, so they follow it by one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state    <= S_DISARMED;
      door_seen    <= 1'b0;
      enable_siren <= 1'b0;
      status       <= 1'b0;
      blink        <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      door_seen    <= door_nxt;
      enable_siren <= (cur_state == S_ALARM) || (cur_state == S_SILENCE);
      status       <= (cur_state inside {S_ENTRY, S_ALARM, S_SILENCE}) ||
                      ((cur_state == S_ARMED) && blink);
      blink        <= (cur_state != S_ARMED) ? 1'b1 : (blink ^ tick);
    end
  end

  for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
    logic [RC_W-1:0] cnt, cnt_inc;
    logic            trip_q, byp_q;

    assign cnt_inc = (cnt == {RC_W{1'b1}}) ? cnt : cnt + RC_W'(1);

    // A zone that keeps tripping, or is still open when the siren times out,
    // is taken out of service until the next ignition.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        cnt    <= '0;
        trip_q <= 1'b0;
        byp_q  <= 1'b0;
      end else if (clear_all) begin
        cnt    <= '0;
        trip_q <= 1'b0;
        byp_q  <= 1'b0;
      end else if (trip_evt && act[i]) begin
        trip_q <= 1'b1;
        cnt    <= cnt_inc;
        if (cnt_inc >= RETRIG_LIM)
          byp_q <= 1'b1;
      end else if (stuck_evt && act[i]) begin
        byp_q <= 1'b1;
      end
    end

    assign tripped[i]  = trip_q;
    assign bypassed[i] = byp_q;
  end

endmodule

// File: tb/tb_multi_zone_alarm_fsm.sv
// Directed testbench for multi_zone_alarm_fsm with a 10-cycle second.
module tb_multi_zone_alarm_fsm;

  localparam int NZ = 4;
  localparam int HZ = 10;
  localparam int TW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ignition = 1'b1;
  logic [NZ-1:0] zone = '0;
  logic [NZ-1:0] entry_mask = 4'b0001;
  logic [TW-1:0] arm_delay = 4'd3;
  logic [TW-1:0] entry_delay = 4'd2;
  logic [TW-1:0] alarm_time = 4'd4;
  logic [2:0]    state;
  logic          status, enable_siren, tick;
  logic [NZ-1:0] tripped, bypassed;
  logic [TW-1:0] time_left;

  int total = 0;
  int bad   = 0;

  multi_zone_alarm_fsm #(
    .N_ZONES(NZ), .CLK_HZ(HZ), .TW(TW), .MAX_RETRIG(3)
  ) dut (
    .clock(clock), .reset(reset), .ignition(ignition), .zone(zone),
    .entry_mask(entry_mask), .arm_delay(arm_delay), .entry_delay(entry_delay),
    .alarm_time(alarm_time), .state(state), .status(status),
    .enable_siren(enable_siren), .tripped(tripped), .bypassed(bypassed),
    .time_left(time_left), .tick(tick)
  );

  always #5 clock = ~clock;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset;
    #2;
    total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", state); end
    total++; if (status !== 1'b0) begin bad++; $display("[TB] FAIL reset_status got=%b want=0", status); end
    total++; if (enable_siren !== 1'b0) begin bad++; $display("[TB] FAIL reset_siren got=%b want=0", enable_siren); end
    total++; if (time_left !== 4'd0) begin bad++; $display("[TB] FAIL reset_time got=%0d want=0", time_left); end
    total++; if (tick !== 1'b0) begin bad++; $display("[TB] FAIL reset_tick got=%b want=0", tick); end
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_arm_sequence;
    @(negedge clock); ignition = 1'b0; zone = 4'b0001;
    @(negedge clock); zone = 4'b0000;
    @(negedge clock);
    total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL arm_state got=%0d want=1", state); end
    total++; if (time_left !== 4'd3) begin bad++; $display("[TB] FAIL arm_load got=%0d want=3", time_left); end
    wait_neg(8);
    total++; if (tick !== 1'b0) begin bad++; $display("[TB] FAIL arm_tick_low got=%b want=0", tick); end
    wait_neg(1);
    total++; if (tick !== 1'b1) begin bad++; $display("[TB] FAIL arm_tick_high got=%b want=1", tick); end
    total++; if (time_left !== 4'd3) begin bad++; $display("[TB] FAIL arm_t9 got=%0d want=3", time_left); end
    wait_neg(1);
    total++; if (time_left !== 4'd2) begin bad++; $display("[TB] FAIL arm_t10 got=%0d want=2", time_left); end
  endtask

  task automatic test_exit_abort;
    zone = 4'b0100;
    @(negedge clock);
    total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL abort_state got=%0d want=0", state); end
    zone = 4'b0000;
    @(negedge clock);
    total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL rearm_state got=%0d want=1", state); end
    total++; if (time_left !== 4'd3) begin bad++; $display("[TB] FAIL rearm_load got=%0d want=3", time_left); end
  endtask

  task automatic test_armed_timing;
    wait_neg(29);
    total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL arming_29 got=%0d want=1", state); end
    wait_neg(1);
    total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL armed_30 got=%0d want=2", state); end
    wait_neg(1);
    total++; if (status !== 1'b1) begin bad++; $display("[TB] FAIL blink_k1 got=%b want=1", status); end
    wait_neg(9);
    total++; if (status !== 1'b1) begin bad++; $display("[TB] FAIL blink_k10 got=%b want=1", status); end
    wait_neg(1);
    total++; if (status !== 1'b0) begin bad++; $display("[TB] FAIL blink_k11 got=%b want=0", status); end
    wait_neg(10);
    total++; if (status !== 1'b1) begin bad++; $display("[TB] FAIL blink_k21 got=%b want=1", status); end
    total++; if (enable_siren !== 1'b0) begin bad++; $display("[TB] FAIL armed_siren got=%b want=0", enable_siren); end
  endtask

  task automatic test_entry_path;
    zone = 4'b0001;
    @(negedge clock);
    total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL entry_state got=%0d want=3", state); end
    total++; if (time_left !== 4'd2) begin bad++; $display("[TB] FAIL entry_load got=%0d want=2", time_left); end
    wait_neg(19);
    total++; if (state !== 3'd3) begin bad++; $display("[TB] FAIL entry_19 got=%0d want=3", state); end
    wait_neg(1);
    total++; if (state !== 3'd4) begin bad++; $display("[TB] FAIL entry_alarm got=%0d want=4", state); end
    total++; if (tripped !== 4'b0001) begin bad++; $display("[TB] FAIL entry_trip got=%b want=0001", tripped); end
    total++; if (time_left !== 4'd4) begin bad++; $display("[TB] FAIL alarm_load got=%0d want=4", time_left); end
    wait_neg(1);
    total++; if (enable_siren !== 1'b1) begin bad++; $display("[TB] FAIL entry_siren got=%b want=1", enable_siren); end
  endtask

  task automatic test_silence_rearm;
    zone = 4'b0000;
    @(negedge clock);
    total++; if (state !== 3'd5) begin bad++; $display("[TB] FAIL silence_state got=%0d want=5", state); end
    @(negedge clock);
    total++; if (enable_siren !== 1'b1) begin bad++; $display("[TB] FAIL silence_siren got=%b want=1", enable_siren); end
    zone = 4'b0010;
    @(negedge clock);
    total++; if (state !== 3'd4) begin bad++; $display("[TB] FAIL realarm_state got=%0d want=4", state); end
    total++; if (tripped !== 4'b0001) begin bad++; $display("[TB] FAIL realarm_trip got=%b want=0001", tripped); end
    zone = 4'b0000;
    @(negedge clock);
    wait_neg(39);
    total++; if (state !== 3'd5) begin bad++; $display("[TB] FAIL silence_39 got=%0d want=5", state); end
    wait_neg(1);
    total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL silence_done got=%0d want=2", state); end
    wait_neg(1);
    total++; if (enable_siren !== 1'b0) begin bad++; $display("[TB] FAIL rearm_siren got=%b want=0", enable_siren); end
  endtask

  task automatic test_instant_priority;
    zone = 4'b0011;
    @(negedge clock);
    total++; if (state !== 3'd4) begin bad++; $display("[TB] FAIL inst_state got=%0d want=4", state); end
    total++; if (tripped !== 4'b0011) begin bad++; $display("[TB] FAIL inst_trip got=%b want=0011", tripped); end
    total++; if (bypassed !== 4'b0000) begin bad++; $display("[TB] FAIL inst_byp got=%b want=0000", bypassed); end
    zone = 4'b0000;
    wait_neg(41);
    total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL inst_rearm got=%0d want=2", state); end
  endtask

  task automatic test_stuck_zone;
    zone = 4'b1000;
    @(negedge clock);
    total++; if (tripped !== 4'b1011) begin bad++; $display("[TB] FAIL stuck_trip got=%b want=1011", tripped); end
    wait_neg(39);
    total++; if (state !== 3'd4) begin bad++; $display("[TB] FAIL stuck_39 got=%0d want=4", state); end
    wait_neg(1);
    total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL stuck_armed got=%0d want=2", state); end
    total++; if (bypassed !== 4'b1000) begin bad++; $display("[TB] FAIL stuck_byp got=%b want=1000", bypassed); end
    wait_neg(30);
    total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL stuck_hold got=%0d want=2", state); end
    total++; if (enable_siren !== 1'b0) begin bad++; $display("[TB] FAIL stuck_siren got=%b want=0", enable_siren); end
  endtask

  task automatic test_retrigger_bypass;
    entry_mask = 4'b0000; zone = 4'b1001;
    @(negedge clock);
    total++; if (state !== 3'd4) begin bad++; $display("[TB] FAIL retrig_state got=%0d want=4", state); end
    total++; if (bypassed !== 4'b1001) begin bad++; $display("[TB] FAIL retrig_byp got=%b want=1001", bypassed); end
    @(negedge clock);
    total++; if (state !== 3'd5) begin bad++; $display("[TB] FAIL retrig_quiet got=%0d want=5", state); end
  endtask

  task automatic test_ignition_override;
    ignition = 1'b1;
    @(negedge clock);
    total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL ign_state got=%0d want=0", state); end
    total++; if (bypassed !== 4'b0000) begin bad++; $display("[TB] FAIL ign_byp got=%b want=0000", bypassed); end
    total++; if (tripped !== 4'b0000) begin bad++; $display("[TB] FAIL ign_trip got=%b want=0000", tripped); end
  endtask

  task automatic test_async_reset;
    ignition = 1'b0; entry_mask = 4'b0001; zone = 4'b0001;
    @(negedge clock); zone = 4'b0000;
    @(negedge clock);
    total++; if (state !== 3'd1) begin bad++; $display("[TB] FAIL ar_arming got=%0d want=1", state); end
    wait_neg(30);
    total++; if (state !== 3'd2) begin bad++; $display("[TB] FAIL ar_armed got=%0d want=2", state); end
    zone = 4'b1000;
    wait_neg(2);
    total++; if (enable_siren !== 1'b1) begin bad++; $display("[TB] FAIL ar_siren got=%b want=1", enable_siren); end
    #2 reset = 1'b0;
    #1;
    total++; if (state !== 3'd0) begin bad++; $display("[TB] FAIL ar_state got=%0d want=0", state); end
    total++; if (enable_siren !== 1'b0) begin bad++; $display("[TB] FAIL ar_siren_off got=%b want=0", enable_siren); end
    total++; if (status !== 1'b0) begin bad++; $display("[TB] FAIL ar_status got=%b want=0", status); end
    total++; if (tripped !== 4'b0000) begin bad++; $display("[TB] FAIL ar_trip got=%b want=0000", tripped); end
    total++; if (bypassed !== 4'b0000) begin bad++; $display("[TB] FAIL ar_byp got=%b want=0000", bypassed); end
    total++; if (time_left !== 4'd0) begin bad++; $display("[TB] FAIL ar_time got=%0d want=0", time_left); end
    total++; if (tick !== 1'b0) begin bad++; $display("[TB] FAIL ar_tick got=%b want=0", tick); end
  endtask

  initial begin
    test_reset();
    test_arm_sequence();
    test_exit_abort();
    test_armed_timing();
    test_entry_path();
    test_silence_rearm();
    test_instant_priority();
    test_stuck_zone();
    test_retrigger_bypass();
    test_ignition_override();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_zone_alarm_fsm.md
Name: multi_zone_alarm_fsm

Overview:
- Parametrised successor to the single-door alarm controller. Supervises N_ZONES debounced intrusion zones, each either a delayed entry zone (door) or an instant zone.
- Runs the arm / exit-delay / entry-delay / alarm / silence sequence with its own seconds countdown.
- Tracks per-zone trip and retrigger history, and auto-bypasses stuck zones.
- Sits between the input debouncers and the siren generator / status LED / display drivers.

Parameters:
- N_ZONES, 4: number of zone inputs (1..16).
- CLK_HZ, 100000000: clock cycles per 1 s tick.
- TW, 4: width of the time-value inputs and of the countdown.
- MAX_RETRIG, 3: alarm triggers by one zone before that zone is bypassed (1..7).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ignition  in  1  debounced ignition; 1 = on.
- zone  in  N_ZONES  debounced zone inputs; 1 = open.
- entry_mask  in  N_ZONES  1 = entry-delay zone, 0 = instant zone. Sampled every cycle.
- arm_delay  in  TW  exit delay, in seconds.
- entry_delay  in  TW  entry delay, in seconds.
- alarm_time  in  TW  siren / silence duration, in seconds.
- state  out  3  current state, for the display.
- status  out  1  status LED.
- enable_siren  out  1  siren enable.
- tripped  out  N_ZONES  sticky: zones that caused an alarm.
- bypassed  out  N_ZONES  zones currently ignored.
- time_left  out  TW  current countdown value.
- tick  out  1  one-cycle 1 Hz pulse.

Behaviour:
- Reset (reset=0), asynchronous. state=DISARMED, door_seen=0, all counters, tripped, bypassed, time_left and prescaler = 0. status=0, enable_siren=0, tick=0.
- Tick and timer:
  - The prescaler counts 0..CLK_HZ-1 and pulses tick at wrap.
  - Load(V): time_left=V and the prescaler restarts at 0.
  - Each tick decrements time_left while it is nonzero.
  - expired = one-cycle pulse on the tick that takes time_left from 1 to 0. If V=0, expired pulses the cycle after the load.
  - Timeout therefore occurs exactly V*CLK_HZ cycles after the load.
- Active zones: act = zone & ~bypassed. Entry-zone hits are act & entry_mask; instant hits are act & ~entry_mask.
- Global override: ignition=1 in any state forces DISARMED next cycle and clears door_seen, tripped, bypassed and the retrigger counters. It takes priority over every other transition.
- State encoding: DISARMED=0, ARMING=1, ARMED=2, ENTRY=3, ALARM=4, SILENCE=5. Codes 6 and 7 recover to DISARMED.
- DISARMED:
  - ignition=0 and any entry-zone input open: set door_seen.
  - door_seen=1 and zone==0: go to ARMING, Load(arm_delay), clear door_seen.
- ARMING:
  - any zone open: go to DISARMED with door_seen=1.
  - else expired: go to ARMED.
- ARMED:
  - any instant hit: go to ALARM, Load(alarm_time).
  - else any entry hit: go to ENTRY, Load(entry_delay).
  - Instant wins when both occur in the same cycle.
- ENTRY:
  - instant hit or expired: go to ALARM, Load(alarm_time).
- On every transition into ALARM from ARMED or ENTRY:
  - For each zone with an act bit: tripped|=1 and its 3-bit retrigger counter increments (saturating).
  - A counter reaching MAX_RETRIG sets that zone's bypassed bit in the same cycle.
- ALARM:
  - act==0: go to SILENCE, Load(alarm_time).
  - else expired: go to ARMED, and bypass every zone still in act (stuck sensor).
- SILENCE:
  - any act bit: go to ALARM, Load(alarm_time). This re-entry does not count as a retrigger.
  - else expired: go to ARMED.
- Outputs, all registered (one cycle after the state change):
  - enable_siren = 1 in ALARM or SILENCE.
  - status = 1 in ENTRY, ALARM and SILENCE. In ARMED it toggles on each tick, starting at 1 on entry. Otherwise 0.
- If all zones are bypassed, ARMED stays in ARMED until ignition.

Decomposition:
- Shared package alarm_pkg holds:
  - state codes S_DISARMED .. S_SILENCE;
  - a 3-bit state typedef;
  - the retrigger counter width.
- One sub-module: second_timer (prescaler, tick, load/countdown, expired), parametrised by CLK_HZ and TW.
- The zone bookkeeping stays in the top module as a generate loop.

Test Plan:
- Arm sequence (CLK_HZ=10, arm_delay=3, entry_mask=4'b0001): ignition 1→0, zone=0001, then zone=0000 → ARMING, time_left=3. ARMED exactly 30 cycles after the ARMING load. status toggles every 10 cycles.
- Exit-delay abort: in ARMING at time_left=2, zone=0100 → DISARMED with door_seen=1. zone=0000 → ARMING again, time_left reloaded to 3.
- Entry path (entry_delay=2, alarm_time=4): in ARMED, zone=0001 → ENTRY. ALARM after 20 cycles; enable_siren=1, tripped=0001.
- Instant priority: in ARMED, zone=0011 with entry_mask=0001 in one cycle → ALARM directly, not ENTRY. tripped=0011.
- Silence / rearm: in ALARM, zone→0000 → SILENCE with siren still on. zone=0010 in SILENCE → ALARM. Close zones and wait 40 cycles → ARMED, enable_siren=0.
- Stuck zone and override: hold zone=1000 (instant) through ALARM; alarm_time=4 expires → ARMED with bypassed=1000, and no new alarm while 1000 stays open. ignition=1 → DISARMED, bypassed=0000, tripped=0000. Drop reset mid-ALARM → all outputs 0 asynchronously.
